// File: rtl/soc_ahb42mem_master_pkg.sv
// ============================================================================
// Package : soc_ahb4_pkg
// AHB4 encodings shared by the native-to-AHB4 master bridge.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package soc_ahb4_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // hsize encoding of a transfer that covers every lane of the bus.
  function automatic logic [2:0] full_lane_size(input int lanes);
    if (lanes >= 4)      return HSIZE_WORD;
    else if (lanes == 2) return HSIZE_HALF;
    else                 return HSIZE_BYTE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/soc_ahb42mem_master_if.sv
// ============================================================================
// Interface : soc_ahb42mem_master_if
// Native request port plus AHB4 master-side bus of the memory bridge.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface soc_ahb42mem_master_if #(
  parameter int PLEN = 32,
  parameter int XLEN = 32
);
  localparam int SW = XLEN / 8;

  logic            req_i;
  logic            we_i;
  logic [PLEN-1:0] addr_i;
  logic [XLEN-1:0] wdata_i;
  logic [SW-1:0]   be_i;
  logic            ack_o;
  logic            rvalid_o;
  logic [XLEN-1:0] rdata_o;
  logic            err_o;

  logic            ahb4_hsel_o;
  logic [PLEN-1:0] ahb4_haddr_o;
  logic [XLEN-1:0] ahb4_hwdata_o;
  logic            ahb4_hwrite_o;
  logic [2:0]      ahb4_hsize_o;
  logic [2:0]      ahb4_hburst_o;
  logic [3:0]      ahb4_hprot_o;
  logic [1:0]      ahb4_htrans_o;
  logic            ahb4_hmastlock_o;
  logic [XLEN-1:0] ahb4_hrdata_i;
  logic            ahb4_hready_i;
  logic            ahb4_hresp_i;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    input  ahb4_hrdata_i, ahb4_hready_i, ahb4_hresp_i,
    output ack_o, rvalid_o, rdata_o, err_o,
    output ahb4_hsel_o, ahb4_haddr_o, ahb4_hwdata_o, ahb4_hwrite_o, ahb4_hsize_o,
    output ahb4_hburst_o, ahb4_hprot_o, ahb4_htrans_o, ahb4_hmastlock_o
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, be_i,
    output ahb4_hrdata_i, ahb4_hready_i, ahb4_hresp_i,
    input  ack_o, rvalid_o, rdata_o, err_o,
    input  ahb4_hsel_o, ahb4_haddr_o, ahb4_hwdata_o, ahb4_hwrite_o, ahb4_hsize_o,
    input  ahb4_hburst_o, ahb4_hprot_o, ahb4_htrans_o, ahb4_hmastlock_o
  );

endinterface

`default_nettype wire

// File: rtl/soc_ahb42mem_master_be2size.sv
// ============================================================================
// Module : soc_ahb4_be2size
// Byte-enable pattern to {hsize, address low bits, illegal} decoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module soc_ahb4_be2size
  import soc_ahb4_pkg::*;
#(
  parameter int SW = 4
) (
  input  logic [SW-1:0] be,
  output logic [2:0]    hsize,
  output logic [1:0]    addr_lsb,
  output logic          illegal
);

  always_comb begin
    hsize    = HSIZE_BYTE;
    addr_lsb = 2'd0;
    illegal  = 1'b1;
    if (be == {SW{1'b1}}) begin
      hsize   = full_lane_size(SW);
      illegal = 1'b0;
    end else begin
      for (int i = 0; i < SW; i++) begin
        if (be == SW'(1 << i)) begin
          hsize    = HSIZE_BYTE;
          addr_lsb = 2'(i);
          illegal  = 1'b0;
        end
      end
      // Halfwords only exist as a sub-transfer on a 32-bit bus, and must be aligned.
      if (SW == 4) begin
        for (int i = 0; i < SW; i += 2) begin
          if (be == SW'(3 << i)) begin
            hsize    = HSIZE_HALF;
            addr_lsb = 2'(i);
            illegal  = 1'b0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/soc_ahb42mem_master.sv
// ============================================================================
// Module : soc_ahb42mem_master
// Native req/ack memory port to single NONSEQ AHB4 transfers.
// Optional overlap of address/data phases: SOC_AHB4_MASTER_PIPELINE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module soc_ahb42mem_master
  import soc_ahb4_pkg::*;
#(
  parameter int         PLEN          = 32,
  parameter int         XLEN          = 32,
  parameter logic [3:0] HPROT_DEFAULT = 4'b0011
) (
  input  logic                  ahb4_clk_i,
  input  logic                  ahb4_rst_i,
  soc_ahb42mem_master_if.master bus
);

  localparam int              SW        = XLEN / 8;
  localparam logic [PLEN-1:0] LANE_MASK = PLEN'(SW - 1);

  logic [2:0] w_dec_size;
  logic [1:0] w_dec_lsb;
  logic       w_dec_illegal;

  soc_ahb4_be2size #(.SW(SW)) u_be2size (
    .be       (bus.be_i),
    .hsize    (w_dec_size),
    .addr_lsb (w_dec_lsb),
    .illegal  (w_dec_illegal)
  );

  // Address-phase slot; r_a_ill marks a slot (illegal be or cancelled) that drives IDLE and completes with error.
  logic            r_a_valid;
  logic            r_a_ill;
  logic            r_a_write;
  logic [PLEN-1:0] r_a_addr;
  logic [2:0]      r_a_size;
  logic [XLEN-1:0] r_a_wdata;

  logic            r_d_valid;
  logic            r_d_ill;
  logic            r_d_write;
  logic [XLEN-1:0] r_d_wdata;

  logic            r_err_hold;
  logic            r_rvalid;
  logic            r_err;
  logic [XLEN-1:0] r_rdata;

  logic w_d_done;
  logic w_a_move;
  logic w_a_free;
  logic w_err_first;
  logic w_pipe_ok;
  logic w_ack;

  assign w_d_done    = r_d_valid & bus.ahb4_hready_i;
  assign w_a_move    = r_a_valid & bus.ahb4_hready_i;
  assign w_a_free    = ~r_a_valid | bus.ahb4_hready_i;
  assign w_err_first = r_d_valid & ~r_d_ill & (bus.ahb4_hresp_i == HRESP_ERROR) & ~bus.ahb4_hready_i;

`ifdef SOC_AHB4_MASTER_PIPELINE_EN
  assign w_pipe_ok = 1'b1;
`else
  assign w_pipe_ok = ~r_a_valid &
                     (~r_d_valid | (bus.ahb4_hready_i & (bus.ahb4_hresp_i == HRESP_OKAY)));
`endif

  assign w_ack = bus.req_i & w_a_free & ~r_err_hold & ~w_err_first & w_pipe_ok;

  always_ff @(posedge ahb4_clk_i) begin
    if (ahb4_rst_i) begin
      r_a_valid  <= 1'b0;
      r_a_ill    <= 1'b0;
      r_a_write  <= 1'b0;
      r_a_addr   <= '0;
      r_a_size   <= '0;
      r_a_wdata  <= '0;
      r_d_valid  <= 1'b0;
      r_d_ill    <= 1'b0;
      r_d_write  <= 1'b0;
      r_d_wdata  <= '0;
      r_err_hold <= 1'b0;
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rvalid <= w_d_done;
      r_err    <= w_d_done & (r_d_ill | (bus.ahb4_hresp_i == HRESP_ERROR));
      if (w_d_done) begin
        r_rdata <= (r_d_write | r_d_ill) ? '0 : bus.ahb4_hrdata_i;
      end

      if (w_a_move) begin
        r_d_valid <= 1'b1;
        r_d_ill   <= r_a_ill;
        r_d_write <= r_a_write;
        r_d_wdata <= r_a_wdata;
      end else if (w_d_done) begin
        r_d_valid <= 1'b0;
      end

      if (w_ack) begin
        r_a_valid <= 1'b1;
        r_a_ill   <= w_dec_illegal;
        r_a_write <= bus.we_i;
        r_a_addr  <= (bus.addr_i & ~LANE_MASK) | PLEN'(w_dec_lsb);
        r_a_size  <= w_dec_size;
        r_a_wdata <= bus.wdata_i;
      end else if (w_a_move) begin
        r_a_valid <= 1'b0;
      end else if (w_err_first & r_a_valid) begin
        // Two-cycle ERROR response: withdraw the pending address and report it as failed.
        r_a_ill <= 1'b1;
      end

      if (w_err_first) begin
        r_err_hold <= 1'b1;
      end else if (bus.ahb4_hready_i & ~r_a_valid) begin
        r_err_hold <= 1'b0;
      end
    end
  end

  assign bus.ack_o            = w_ack;
  assign bus.rvalid_o         = r_rvalid;
  assign bus.rdata_o          = r_rdata;
  assign bus.err_o            = r_err;
  assign bus.ahb4_hsel_o      = r_a_valid & ~r_a_ill;
  assign bus.ahb4_htrans_o    = (r_a_valid & ~r_a_ill) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.ahb4_haddr_o     = r_a_addr;
  assign bus.ahb4_hwrite_o    = r_a_write;
  assign bus.ahb4_hsize_o     = r_a_size;
  assign bus.ahb4_hwdata_o    = r_d_wdata;
  assign bus.ahb4_hburst_o    = HBURST_SINGLE;
  assign bus.ahb4_hprot_o     = HPROT_DEFAULT;
  assign bus.ahb4_hmastlock_o = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_soc_ahb42mem_master.sv
// ============================================================================
// Module : tb_soc_ahb42mem_master
// Directed scoreboard bench for soc_ahb42mem_master with a reactive AHB4 slave.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_soc_ahb42mem_master;
  import soc_ahb4_pkg::*;

  localparam int PLEN = 32;
  localparam int XLEN = 32;
`ifdef SOC_AHB4_MASTER_PIPELINE_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  soc_ahb42mem_master_if #(.PLEN(PLEN), .XLEN(XLEN)) bus ();

  soc_ahb42mem_master #(.PLEN(PLEN), .XLEN(XLEN), .HPROT_DEFAULT(4'b0011)) dut (
    .ahb4_clk_i (clk),
    .ahb4_rst_i (rst),
    .bus        (bus)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reactive slave: one data phase tracked, programmable waits and error address.
  int          sl_waits    = 0;
  logic [31:0] sl_err_addr = 32'hFFFF_FFF0;
  logic        dp_valid    = 1'b0;
  logic [31:0] dp_addr     = '0;
  logic        dp_write    = 1'b0;
  int          dp_waits    = 0;
  logic        dp_err      = 1'b0;
  logic        dp_err_seen = 1'b0;
  int          wr_seen_cnt = 0;
  logic [31:0] wr_seen_addr = '0;
  logic [31:0] wr_seen_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      dp_valid          = 1'b0;
      bus.ahb4_hready_i = 1'b1;
      bus.ahb4_hresp_i  = 1'b0;
      bus.ahb4_hrdata_i = '0;
    end else begin
      bus.ahb4_hready_i = 1'b1;
      bus.ahb4_hresp_i  = 1'b0;
      bus.ahb4_hrdata_i = '0;
      if (dp_valid) begin
        if (dp_waits > 0) begin
          bus.ahb4_hready_i = 1'b0;
          dp_waits--;
        end else if (dp_err && !dp_err_seen) begin
          bus.ahb4_hready_i = 1'b0;
          bus.ahb4_hresp_i  = 1'b1;
          dp_err_seen       = 1'b1;
        end else if (dp_err) begin
          bus.ahb4_hresp_i = 1'b1;
        end else if (!dp_write) begin
          bus.ahb4_hrdata_i = rd_model(dp_addr);
        end else begin
          wr_seen_cnt++;
          wr_seen_addr = dp_addr;
          wr_seen_data = bus.ahb4_hwdata_o;
        end
      end
      if (bus.ahb4_hready_i) begin
        dp_valid    = (bus.ahb4_htrans_o == HTRANS_NONSEQ);
        dp_addr     = bus.ahb4_haddr_o;
        dp_write    = bus.ahb4_hwrite_o;
        dp_waits    = sl_waits;
        dp_err      = (bus.ahb4_haddr_o == sl_err_addr);
        dp_err_seen = 1'b0;
      end
    end
  end

  // Completion monitor: every rvalid must match the oldest expected entry, cycle included.
  always @(negedge clk) begin
    #1;
    if (bus.rvalid_o === 1'b1) begin
      tests++;
      assert (sb.size() != 0)
      else begin
        failed++;
        $error("FAIL unexpected_rvalid observed=1 expected=0 at cycle %0d", cyc);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rvalid_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("rdata", bus.rdata_o, mon_e.rdata);
        chk("err", bus.err_o, mon_e.err);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                       input int lat, output int acyc);
    int   n;
    exp_t e;
    n = 0;
    acyc = -1;
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
    bus.be_i    = be;
    while (acyc < 0 && n < 40) begin
      @(negedge clk); #1;
      if (bus.ack_o === 1'b1) begin
        acyc    = cyc;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + lat;
        sb.push_back(e);
      end
      @(posedge clk); #2;
      n++;
    end
    bus.req_i = 1'b0;
    tests++;
    assert (acyc >= 0)
    else begin
      failed++;
      $error("FAIL ack_timeout addr=%0h observed=no_ack expected=ack", addr);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk); #2;
      n++;
    end
    tests++;
    assert (sb.size() == 0)
    else begin
      failed++;
      $error("FAIL drain observed=%0d pending expected=0", sb.size());
    end
    @(posedge clk); #2;
  endtask

  initial begin
    int a;
    int b;
    int acyc [4];
    int wr_before;

    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    bus.be_i    = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_htrans", bus.ahb4_htrans_o, HTRANS_IDLE);
    chk("rst_addr_ctl", {bus.ahb4_hsel_o, bus.ahb4_hwrite_o, bus.ahb4_hsize_o, bus.ahb4_haddr_o}, 64'd0);
    chk("rst_hwdata", bus.ahb4_hwdata_o, 64'd0);
    chk("rst_rsp", {bus.ack_o, bus.rvalid_o, bus.err_o, bus.rdata_o}, 64'd0);
    chk("const_ctl", {bus.ahb4_hburst_o, bus.ahb4_hprot_o, bus.ahb4_hmastlock_o}, {3'b000, 4'b0011, 1'b0});
    @(posedge clk); #2;

    // Zero-wait word read
    issue(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 3, a);
    @(negedge clk); #1;
    chk("t1_htrans", bus.ahb4_htrans_o, HTRANS_NONSEQ);
    chk("t1_hsel", bus.ahb4_hsel_o, 1'b1);
    chk("t1_haddr", bus.ahb4_haddr_o, 32'h100);
    chk("t1_hsize", bus.ahb4_hsize_o, HSIZE_WORD);
    chk("t1_hwrite", bus.ahb4_hwrite_o, 1'b0);
    drain();

    // Byte write on lane 2
    issue(1'b1, 32'h200, 32'h00AB_0000, 4'b0100, 32'h0, 1'b0, 3, a);
    @(negedge clk); #1;
    chk("t2_haddr", bus.ahb4_haddr_o, 32'h202);
    chk("t2_hsize", bus.ahb4_hsize_o, HSIZE_BYTE);
    chk("t2_hwrite", bus.ahb4_hwrite_o, 1'b1);
    @(negedge clk); #1;
    chk("t2_hwdata", bus.ahb4_hwdata_o, 32'h00AB_0000);
    chk("t2_slave_addr", wr_seen_addr, 32'h202);
    drain();

    // Upper halfword write
    issue(1'b1, 32'h600, 32'hBEEF_0000, 4'b1100, 32'h0, 1'b0, 3, a);
    @(negedge clk); #1;
    chk("half_haddr", bus.ahb4_haddr_o, 32'h602);
    chk("half_hsize", bus.ahb4_hsize_o, HSIZE_HALF);
    drain();

    // Back-to-back reads
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'hF, rd_model(32'h1000 + 32'(4 * i)), 1'b0, 3, acyc[i]);
    end
    for (int i = 1; i < 4; i++) begin
      chk("b2b_ack_gap", 64'(acyc[i] - acyc[i-1]), 64'(GAP));
    end
    drain();

    // Two wait states
    sl_waits = 2;
    issue(1'b0, 32'h300, 32'h0, 4'hF, rd_model(32'h300), 1'b0, 5, a);
`ifndef SOC_AHB4_MASTER_PIPELINE_EN
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 32'h304;
    bus.be_i   = 4'hF;
`endif
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      chk("ws_haddr", bus.ahb4_haddr_o, 32'h300);
`ifndef SOC_AHB4_MASTER_PIPELINE_EN
      chk("ws_ack", bus.ack_o, 1'b0);
`endif
      @(posedge clk); #2;
    end
    sl_waits = 0;
`ifndef SOC_AHB4_MASTER_PIPELINE_EN
    issue(1'b0, 32'h304, 32'h0, 4'hF, rd_model(32'h304), 1'b0, 3, b);
    chk("ws_next_ack_cycle", 64'(b), 64'(a + 4));
`endif
    drain();

    // Slave ERROR response
    sl_err_addr = 32'h400;
`ifdef SOC_AHB4_MASTER_PIPELINE_EN
    issue(1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1, 4, a);
    issue(1'b0, 32'h404, 32'h0, 4'hF, 32'h0, 1'b1, 4, b);
    chk("err_pipe_ack", 64'(b), 64'(a + 1));
    @(posedge clk); #2;
    @(negedge clk); #1;
    chk("err_cancel_htrans", bus.ahb4_htrans_o, HTRANS_IDLE);
`else
    issue(1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1, 4, a);
    issue(1'b0, 32'h404, 32'h0, 4'hF, rd_model(32'h404), 1'b0, 3, b);
    chk("err_recover_ack", 64'(b), 64'(a + 4));
`endif
    drain();
    sl_err_addr = 32'hFFFF_FFF0;

    // Illegal byte enables never reach the bus
    wr_before = wr_seen_cnt;
    issue(1'b1, 32'h500, 32'h1234_5678, 4'b0101, 32'h0, 1'b1, 3, a);
    @(negedge clk); #1;
    chk("ill_htrans", bus.ahb4_htrans_o, HTRANS_IDLE);
    chk("ill_hsel", bus.ahb4_hsel_o, 1'b0);
    drain();
    chk("ill_no_bus_write", 64'(wr_seen_cnt), 64'(wr_before));

    // Reset during the data phase drops the transfer
    issue(1'b0, 32'h700, 32'h0, 4'hF, rd_model(32'h700), 1'b0, 3, a);
    @(posedge clk); #2;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("rst_mid_rvalid", bus.rvalid_o, 1'b0);
      chk("rst_mid_htrans", bus.ahb4_htrans_o, HTRANS_IDLE);
      @(posedge clk); #2;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
